// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : Register file with scoreboard and self-initialisation.
//            Optional feature macro: REG_FILE_SB_BYPASS_EN (writeback bypass).
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              init_busy
);

  localparam logic [0:0]        c_ST_INIT  = 1'b0;
  localparam logic [0:0]        c_ST_RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] c_CNT_LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] c_CNT_ONE  = ADDR_W'(1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic              w_init_wr;
  logic              w_run_wr;
  logic              w_out_en;
  logic [DATA_W:0]   w_rd_a;
  logic [DATA_W:0]   w_rd_b;

  // State register and initialisation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_ST_INIT) begin
        r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_ONE;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_INIT: if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_RUN;
      c_ST_RUN:  w_state_nxt = c_ST_RUN;
      default:   w_state_nxt = c_ST_INIT;
    endcase
  end

  // Outputs are held quiet while reset is asserted, not only after its edge
  always_comb begin
    w_init_wr = (r_state == c_ST_INIT);
    w_run_wr  = (r_state == c_ST_RUN);
    w_out_en  = (r_state == c_ST_RUN) && !rst;
    init_busy = !w_out_en;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REGS; k++) begin
      if (!rst) begin
        if (w_init_wr && r_cnt == ADDR_W'(k)) begin
          r_regs[k] <= DATA_W'(k);
        end else if (w_run_wr && wb_en && wb_addr == ADDR_W'(k)) begin
          r_regs[k] <= wb_data;
        end
      end
    end
  end

  // Issue is evaluated after writeback so a same-cycle pair leaves the bit set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (w_run_wr) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (issue_en && issue_addr == ADDR_W'(k)) begin
          r_busy[k] <= 1'b1;
        end else if (wb_en && wb_addr == ADDR_W'(k)) begin
          r_busy[k] <= 1'b0;
        end
      end
    end
  end

  // Returns {busy, data}; unimplemented addresses fall through to zero
  function automatic logic [DATA_W:0] f_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] res;
    res = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr == ADDR_W'(k)) begin
        res = {r_busy[k], r_regs[k]};
`ifdef REG_FILE_SB_BYPASS_EN
        if (wb_en && wb_addr == addr) begin
          res = {(issue_en && issue_addr == addr), wb_data};
        end
`endif
      end
    end
    return res;
  endfunction

  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (w_out_en) begin
      w_rd_a = f_read(rd_addr_a);
      w_rd_b = f_read(rd_addr_b);
    end
  end

  assign rd_data_a = w_rd_a[DATA_W-1:0];
  assign busy_a    = w_rd_a[DATA_W];
  assign rd_data_b = w_rd_b[DATA_W-1:0];
  assign busy_b    = w_rd_b[DATA_W];

endmodule
`default_nettype wire
